// File: rtl/pipe_flow_ctrl.sv
// Valid/allowin flow controller for a 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
// Drives pipe-register load enables, inserts load-use and MDU bubbles, squashes on redirect.

module pipe_flow_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_in,
  input  logic [4:0]        id_rsc,
  input  logic [4:0]        id_rtc,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_mdu,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_wdc,
  input  logic              exc_flush,
  output logic              pc_we,
  output logic              id_allowin,
  output logic              ex_allowin,
  output logic              mem_allowin,
  output logic              id_valid,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  // An MDU op spends MDU_LAT cycles in EX, so the counter starts one short.
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_LAT - 1);

  logic              id_valid_q, id_valid_d;
  logic              ex_valid_q, ex_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic              ex_mdu_q, ex_mdu_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  logic load_use;
  logic id_ready_go;
  logic ex_ready_go;
  logic mem_ready_go;
  logic wb_allowin;
  logic id_to_ex;

  // Only an EX load can stall ID; MEM/WB producers are covered by forwarding.
  assign load_use = id_valid_q && ex_valid_q && ex_is_load && (ex_wdc != 5'd0) &&
                    ((id_use_rs && (id_rsc == ex_wdc)) || (id_use_rt && (id_rtc == ex_wdc)));

  assign mdu_busy     = ex_mdu_q && (mdu_cnt_q != '0);
  assign id_ready_go  = !load_use;
  assign ex_ready_go  = !mdu_busy;
  assign mem_ready_go = 1'b1;
  assign wb_allowin   = 1'b1;

  assign mem_allowin = !mem_valid_q || (mem_ready_go && wb_allowin);
  assign ex_allowin  = !ex_valid_q  || (ex_ready_go  && mem_allowin);
  assign id_allowin  = !id_valid_q  || (id_ready_go  && ex_allowin);
  assign pc_we       = (if_valid_in && id_allowin) || exc_flush;

  assign id_to_ex = id_valid_q && id_ready_go;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    id_valid_d  = id_valid_q;
    ex_valid_d  = ex_valid_q;
    mem_valid_d = mem_valid_q;
    wb_valid_d  = wb_valid_q;
    mdu_cnt_d   = mdu_cnt_q;
    ex_mdu_d    = ex_mdu_q;
    stall_d     = stall_q;

    // WB always accepts, so the instruction in MEM retires even on a redirect.
    if (wb_allowin) begin
      wb_valid_d = mem_valid_q && mem_ready_go;
    end

    if (exc_flush) begin
      id_valid_d  = 1'b0;
      ex_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      mdu_cnt_d   = '0;
      ex_mdu_d    = 1'b0;
    end else begin
      if (id_allowin) begin
        id_valid_d = if_valid_in;
      end

      if (ex_allowin) begin
        ex_valid_d = id_to_ex;
        ex_mdu_d   = id_to_ex && id_is_mdu;
        mdu_cnt_d  = (id_to_ex && id_is_mdu) ? MDU_LOAD : '0;
      end else if (mdu_cnt_q != '0) begin
        mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
      end

      if (mem_allowin) begin
        mem_valid_d = ex_valid_q && ex_ready_go;
      end

      if (id_valid_q && !id_allowin) begin
        stall_d = stall_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      mdu_cnt_q   <= '0;
      ex_mdu_q    <= 1'b0;
      stall_q     <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      mdu_cnt_q   <= mdu_cnt_d;
      ex_mdu_q    <= ex_mdu_d;
      stall_q     <= stall_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign ex_valid     = ex_valid_q;
  assign mem_valid    = mem_valid_q;
  assign wb_valid     = wb_valid_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: a per-instruction stage model drives ID/EX operand inputs
// and predicts every output each cycle; literal checks pin the model at key points.

module tb_pipe_flow_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_valid_in;
  logic [4:0]  id_rsc, id_rtc, ex_wdc;
  logic        id_use_rs, id_use_rt, id_is_mdu, ex_is_load, exc_flush;
  logic        pc_we, id_allowin, ex_allowin, mem_allowin;
  logic        id_valid, ex_valid, mem_valid, wb_valid, mdu_busy;
  logic [31:0] stall_cycles;

  logic        pc_we1, id_allowin1, ex_allowin1, mem_allowin1;
  logic        id_valid1, ex_valid1, mem_valid1, wb_valid1, mdu_busy1;
  logic [31:0] stall_cycles1;

  pipe_flow_ctrl #(.MDU_LAT(LAT), .CNT_W(6), .PERF_W(32)) u_dut (
    .clk(clk), .rst(rst), .if_valid_in(if_valid_in),
    .id_rsc(id_rsc), .id_rtc(id_rtc), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_mdu(id_is_mdu), .ex_is_load(ex_is_load), .ex_wdc(ex_wdc), .exc_flush(exc_flush),
    .pc_we(pc_we), .id_allowin(id_allowin), .ex_allowin(ex_allowin), .mem_allowin(mem_allowin),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  // Single-cycle MDU variant: an MDU op must never hold EX.
  pipe_flow_ctrl #(.MDU_LAT(1), .CNT_W(6), .PERF_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .if_valid_in(if_valid_in),
    .id_rsc(id_rsc), .id_rtc(id_rtc), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_mdu(id_is_mdu), .ex_is_load(ex_is_load), .ex_wdc(ex_wdc), .exc_flush(exc_flush),
    .pc_we(pc_we1), .id_allowin(id_allowin1), .ex_allowin(ex_allowin1), .mem_allowin(mem_allowin1),
    .id_valid(id_valid1), .ex_valid(ex_valid1), .mem_valid(mem_valid1), .wb_valid(wb_valid1),
    .mdu_busy(mdu_busy1), .stall_cycles(stall_cycles1)
  );

  typedef struct packed {
    logic       v;
    logic       mdu;
    logic       load;
    logic [4:0] wd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
  } ins_t;

  function automatic ins_t mk(logic mdu, logic load, logic [4:0] wd, logic [4:0] rs,
                              logic [4:0] rt, logic urs, logic urt);
    ins_t r;
    r.v = 1'b1; r.mdu = mdu; r.load = load; r.wd = wd;
    r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    return r;
  endfunction

  // Model: which instruction sits in each stage, and how many EX cycles the EX op still needs.
  ins_t        m_id, m_ex, m_mem, m_wb;
  int          occ;
  logic [31:0] m_stall;
  logic        cur_ifv, cur_flush;
  ins_t        cur_fetch;
  logic        s_hazard, s_ex_stuck, s_id_stuck;
  logic        exp_pc_we, exp_id_allowin, exp_ex_allowin, exp_busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit win_en   = 1'b0;
  int wb_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_id = '0; m_ex = '0; m_mem = '0; m_wb = '0;
    occ = 0; m_stall = '0;
  endtask

  task automatic drive(input logic ifv, input logic flush, input ins_t f);
    cur_ifv = ifv; cur_flush = flush; cur_fetch = f;
    if_valid_in = ifv;
    exc_flush   = flush;
    id_rsc      = m_id.rs;
    id_rtc      = m_id.rt;
    id_use_rs   = m_id.urs;
    id_use_rt   = m_id.urt;
    id_is_mdu   = m_id.mdu;
    ex_is_load  = m_ex.load;
    ex_wdc      = m_ex.wd;
    s_ex_stuck  = m_ex.v && m_ex.mdu && (occ > 1);
    s_hazard    = m_id.v && m_ex.v && m_ex.load && (m_ex.wd != 5'd0) &&
                  ((m_id.urs && m_id.rs == m_ex.wd) || (m_id.urt && m_id.rt == m_ex.wd));
    s_id_stuck  = m_id.v && (s_hazard || s_ex_stuck);
    exp_ex_allowin = !s_ex_stuck;
    exp_id_allowin = !s_id_stuck;
    exp_pc_we      = (ifv && !s_id_stuck) || flush;
    exp_busy       = s_ex_stuck;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (cur_flush) begin
      m_wb = m_mem;
      m_mem.v = 1'b0; m_ex.v = 1'b0; m_id.v = 1'b0;
      occ = 0;
    end else begin
      if (s_id_stuck) m_stall++;
      m_wb = m_mem;
      if (s_ex_stuck) begin
        m_mem.v = 1'b0;
        occ--;
      end else begin
        m_mem = m_ex;
        if (m_id.v && !s_hazard) begin
          m_ex = m_id;
          occ  = m_id.mdu ? LAT : 1;
        end else begin
          m_ex.v = 1'b0;
        end
      end
      if (!s_id_stuck) begin
        m_id   = cur_fetch;
        m_id.v = cur_ifv;
      end
    end
    #1;
  endtask

  task automatic cyc(input logic ifv, input logic flush, input ins_t f);
    drive(ifv, flush, f);
    tick();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc_we", pc_we, exp_pc_we);
      check("id_allowin", id_allowin, exp_id_allowin);
      check("ex_allowin", ex_allowin, exp_ex_allowin);
      check("mem_allowin", mem_allowin, 1);
      check("id_valid", id_valid, m_id.v);
      check("ex_valid", ex_valid, m_ex.v);
      check("mem_valid", mem_valid, m_mem.v);
      check("wb_valid", wb_valid, m_wb.v);
      check("mdu_busy", mdu_busy, exp_busy);
      check("stall_cycles", stall_cycles, m_stall);
      check("lat1_mdu_busy", mdu_busy1, 0);
      check("lat1_ex_allowin", ex_allowin1, 1);
      if (win_en && wb_valid) wb_seen++;
    end
  end

  ins_t nop, mdu_op;
  logic gap_pat [13];

  initial begin
    nop    = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    mdu_op = mk(1, 0, 5'd0, 5'd1, 5'd2, 1, 1);
    gap_pat = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};

    // Reset
    model_reset();
    rst = 1'b1;
    drive(1, 0, nop);
    tick();
    tick();
    rst = 1'b0;
    drive(1, 0, nop);
    cmp_en = 1'b1;
    check("rst_id_valid", id_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_busy", mdu_busy, 0);
    check("rst_id_allowin", id_allowin, 1);
    check("rst_ex_allowin", ex_allowin, 1);
    check("rst_pc_we", pc_we, 1);

    // 1: free-flowing stream
    tick();
    check("t1_id_after1", id_valid, 1);
    check("t1_ex_after1", ex_valid, 0);
    cyc(1, 0, nop);
    cyc(1, 0, nop);
    cyc(1, 0, nop);
    check("t1_mem_after4", mem_valid, 1);
    check("t1_wb_after4", wb_valid, 1);
    cyc(1, 0, nop);
    cyc(1, 0, nop);
    check("t1_stall", stall_cycles, 0);

    // 2: load-use on rs, then $0 destination, unused operands, and rt hazard
    cyc(1, 0, mk(0, 1, 5'd5, 5'd0, 5'd0, 0, 0));
    cyc(1, 0, mk(0, 0, 5'd0, 5'd5, 5'd0, 1, 0));
    drive(1, 0, nop);
    check("t2_stall_id_allowin", id_allowin, 0);
    check("t2_stall_pc_we", pc_we, 0);
    tick();
    check("t2_bubble_ex", ex_valid, 0);
    check("t2_load_in_mem", mem_valid, 1);
    check("t2_stall_cnt", stall_cycles, 1);
    drive(1, 0, nop);
    check("t2_resume_id_allowin", id_allowin, 1);
    tick();
    check("t2_user_in_ex", ex_valid, 1);

    cyc(1, 0, mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0));
    cyc(1, 0, mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 1));
    drive(1, 0, nop);
    check("t2_wd0_no_stall", id_allowin, 1);
    tick();
    check("t2_wd0_stall_cnt", stall_cycles, 1);

    cyc(1, 0, mk(0, 1, 5'd7, 5'd0, 5'd0, 0, 0));
    cyc(1, 0, mk(0, 0, 5'd0, 5'd7, 5'd7, 0, 0));
    drive(1, 0, nop);
    check("t2_unused_no_stall", id_allowin, 1);
    tick();

    cyc(1, 0, mk(0, 1, 5'd9, 5'd0, 5'd0, 0, 0));
    cyc(1, 0, mk(0, 0, 5'd0, 5'd1, 5'd9, 0, 1));
    drive(1, 0, nop);
    check("t2_rt_stall", id_allowin, 0);
    tick();
    cyc(1, 0, nop);
    check("t2_rt_stall_cnt", stall_cycles, 2);

    // 3: MDU occupies EX for LAT cycles
    cyc(1, 0, mdu_op);
    cyc(1, 0, nop);
    check("t3_busy_on_entry", mdu_busy, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, nop);
      check("t3_busy", mdu_busy, 1);
      check("t3_ex_allowin", ex_allowin, 0);
      check("t3_id_allowin", id_allowin, 0);
      tick();
      check("t3_mem_bubble", mem_valid, 0);
    end
    drive(1, 0, nop);
    check("t3_busy_done", mdu_busy, 0);
    check("t3_ex_allowin_done", ex_allowin, 1);
    tick();
    check("t3_mdu_in_mem", mem_valid, 1);
    check("t3_stall_cnt", stall_cycles, 5);

    // 4: redirect during an MDU stall
    cyc(1, 0, mdu_op);
    cyc(1, 0, nop);
    drive(1, 1, nop);
    check("t4_pc_we", pc_we, 1);
    check("t4_all_valid", {id_valid, ex_valid, mem_valid, wb_valid, mdu_busy}, 5'b11111);
    tick();
    check("t4_squashed", {id_valid, ex_valid, mem_valid}, 3'b000);
    check("t4_busy", mdu_busy, 0);
    check("t4_wb_retires", wb_valid, 1);
    check("t4_stall_cnt", stall_cycles, 5);

    // 5: fetch gap, then drain; one retire from the flush plus six fetched
    wb_seen = 0;
    win_en  = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(gap_pat[i], 0, nop);
      if (!gap_pat[i]) check("t5_gap_pc_we", pc_we, 0);
      tick();
      if (i == 3 || i == 4) check("t5_gap_id_valid", id_valid, 0);
    end
    win_en = 1'b0;
    check("t5_retired", wb_seen, 7);

    // 6: reset during an MDU stall
    cyc(1, 0, mdu_op);
    cyc(1, 0, nop);
    cyc(1, 0, nop);
    cyc(1, 0, nop);
    check("t6_pre_stall", stall_cycles, 7);
    check("t6_pre_busy", mdu_busy, 1);
    rst = 1'b1;
    drive(1, 0, nop);
    tick();
    rst = 1'b0;
    check("t6_valids", {id_valid, ex_valid, mem_valid, wb_valid}, 4'b0000);
    check("t6_busy", mdu_busy, 0);
    check("t6_stall", stall_cycles, 0);
    drive(1, 0, nop);
    check("t6_id_allowin", id_allowin, 1);
    tick();
    cyc(1, 0, nop);
    cyc(1, 0, nop);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
